// File: rtl/node_mac_seq.sv
// Time-multiplexed neuron: bias + N_IN weight*activation MACs, round/shift, activation (ReLU when NODE_RELU_EN, else linear clamp).
// Latency: out_valid rises N_IN+1 edges after the accepting edge; one vector in flight, issue interval N_IN+3.
// Backpressure: result and out_valid held while out_ready=0; in_ready low outside IDLE; writes outside IDLE are dropped with w_err.
module node_mac_seq #(
  parameter int N_IN       = 10,
  parameter int DW         = 8,
  parameter int WW         = 8,
  parameter int BW         = 16,
  parameter int FRAC_SHIFT = 6,
  parameter int AW         = $clog2(N_IN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*DW-1:0]   in_data,
  input  logic                 w_wr_en,
  input  logic [AW-1:0]        w_wr_addr,
  input  logic [BW-1:0]        w_wr_data,
  output logic                 w_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data
);

  localparam int ACC_W = DW + WW + $clog2(N_IN) + 2;
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW    = DW + WW;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DW - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_OUT} state_t;

  state_t state, state_nxt;

  logic                    accept;
  logic                    mac_last;
  logic                    wr_ok;
  logic                    wr_drop;
  logic [IW-1:0]           idx;
  logic signed [DW-1:0]    act_q [N_IN];
  logic signed [WW-1:0]    wgt_q [N_IN];
  logic signed [BW-1:0]    bias_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] rnd;
  logic [DW-1:0]           act_res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        accept = in_valid && in_ready;
        if (accept) state_nxt = S_MAC;
      end
      S_MAC:   if (mac_last) state_nxt = S_ACT;
      S_ACT:   state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mac_last = (idx == IW'(N_IN - 1));
  // Input acceptance takes priority over a coincident coefficient write.
  assign wr_ok    = w_wr_en && (state == S_IDLE) && !accept && (w_wr_addr <= AW'(N_IN));
  assign wr_drop  = w_wr_en && !wr_ok;

  // Registered so in_ready is low throughout reset and rises on the first clock in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_ready <= 1'b0;
    else        in_ready <= (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) wgt_q[i] <= '0;
      bias_q <= '0;
      w_err  <= 1'b0;
    end else begin
      w_err <= wr_drop;
      if (wr_ok) begin
        if (w_wr_addr == AW'(N_IN)) bias_q <= w_wr_data;
        else                        wgt_q[w_wr_addr] <= w_wr_data[WW-1:0];
      end
    end
  end

  assign prod     = act_q[idx] * wgt_q[idx];
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(ACC_W-BW){bias_q[BW-1]}}, bias_q};
  assign rnd      = (acc + RND) >>> FRAC_SHIFT;

  always_comb begin
    act_res = rnd[DW-1:0];
`ifdef NODE_RELU_EN
    if (rnd[ACC_W-1])      act_res = '0;
    else if (rnd > SAT_MAX) act_res = SAT_MAX[DW-1:0];
`else
    if (rnd > SAT_MAX)      act_res = SAT_MAX[DW-1:0];
    else if (rnd < SAT_MIN) act_res = SAT_MIN[DW-1:0];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) act_q[i] <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          for (int i = 0; i < N_IN; i++) act_q[i] <= in_data[i*DW +: DW];
          acc <= bias_ext;
          idx <= '0;
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + IW'(1);
        end
        S_ACT: begin
          out_data  <= act_res;
          out_valid <= 1'b1;
        end
        S_OUT:   if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_mac_seq.sv
// Bench for node_mac_seq: directed cases from the neuron's rules plus randomized vectors against an arithmetic model.
module tb_node_mac_seq;
  localparam int N_IN = 10, DW = 8, WW = 8, BW = 16, FRAC_SHIFT = 6;
  localparam int AW = $clog2(N_IN + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N_IN*DW-1:0] in_data = '0;
  logic w_wr_en = 1'b0;
  logic [AW-1:0] w_wr_addr = '0;
  logic [BW-1:0] w_wr_data = '0;
  logic w_err;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int mw[N_IN];
  int mb = 0;
  int dflt_w[N_IN] = '{15, -15, 0, 5, -12, -15, 7, 0, -11, -1};

  node_mac_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .w_err(w_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: integer sum, floor division for the rounding shift, then clamp.
  function automatic int model_out(input logic [N_IN*DW-1:0] d);
    longint acc, s, div, hi, lo;
    int a;
    div = longint'(1) << FRAC_SHIFT;
    hi  = (longint'(1) << (DW - 1)) - 1;
    lo  = -(longint'(1) << (DW - 1));
    acc = mb;
    for (int i = 0; i < N_IN; i++) begin
      a = $signed(d[i*DW +: DW]);
      acc += longint'(a) * longint'(mw[i]);
    end
    s = acc + div / 2;
    if (s >= 0) s = s / div;
    else        s = -((-s + div - 1) / div);
`ifdef NODE_RELU_EN
    if (s < 0)  s = 0;
    if (s > hi) s = hi;
`else
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`endif
    return int'(s);
  endfunction

  function automatic logic [N_IN*DW-1:0] rand_vec();
    logic [N_IN*DW-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [N_IN*DW-1:0] fill_vec(input int val);
    logic [N_IN*DW-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = DW'(val);
    return v;
  endfunction

  task automatic write_w(input int addr, input int data, input logic exp_err);
    logic signed [BW-1:0] bv;
    logic signed [WW-1:0] wv;
    w_wr_en = 1'b1; w_wr_addr = AW'(addr); w_wr_data = BW'(data);
    @(posedge clk); #1;
    w_wr_en = 1'b0;
    checks++;
    if (w_err !== exp_err) begin
      errors++; $display("FAIL write_err addr=%0d got %b want %b", addr, w_err, exp_err);
    end
    if (exp_err) begin
      @(posedge clk); #1;
      checks++;
      if (w_err !== 1'b0) begin errors++; $display("FAIL w_err_pulse got %b want 0", w_err); end
    end else begin
      bv = data[BW-1:0];
      wv = data[WW-1:0];
      if (addr == N_IN) mb = int'(bv);
      else              mw[addr] = int'(wv);
    end
  endtask

  task automatic start_vec(input logic [N_IN*DW-1:0] d);
    int n = 0;
    in_data = d; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_wait got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; t0 = cyc;
  endtask

  task automatic finish_vec(output logic [DW-1:0] res, output int lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid_wait got %b want 1", out_valid); end
    res = out_data; lat = cyc - t0;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic program_default(input int bias);
    for (int i = 0; i < N_IN; i++) write_w(i, dflt_w[i], 1'b0);
    write_w(N_IN, bias, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (out_data !== 8'h00)  begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
    if (w_err !== 1'b0)      begin errors++; $display("FAIL rst_w_err got %b want 0", w_err); end
    reset = 1'b1;
    for (int i = 0; i < N_IN; i++) mw[i] = 0;
    mb = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero_input();
    logic [DW-1:0] res; int lat;
    program_default(1024);
    start_vec(fill_vec(0));
    finish_vec(res, lat);
    checks += 2;
    if (res !== 8'd16)     begin errors++; $display("FAIL zero_data got %0d want 16", res); end
    if (lat != N_IN + 1)   begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, N_IN + 1); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] res; int lat;
    out_ready = 1'b0;
    start_vec(fill_vec(10));
    finish_vec(res, lat);
    checks++;
    if (res !== 8'd12) begin errors++; $display("FAIL tens_data got %0d want 12", res); end
    repeat (5) begin
      @(posedge clk); #1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b want 1", out_valid); end
      if (out_data !== 8'd12) begin errors++; $display("FAIL hold_data got %0d want 12", out_data); end
      if (in_ready !== 1'b0)  begin errors++; $display("FAIL hold_in_ready got %b want 0", in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_write_during_mac();
    logic [N_IN*DW-1:0] d; logic [DW-1:0] res, expv; int lat;
    d = rand_vec();
    expv = DW'(model_out(d));
    start_vec(d);
    repeat (3) @(posedge clk);
    #1;
    w_wr_en = 1'b1; w_wr_addr = AW'(0); w_wr_data = BW'(100);
    @(posedge clk); #1;
    w_wr_en = 1'b0;
    checks++;
    if (w_err !== 1'b1) begin errors++; $display("FAIL mac_write_err got %b want 1", w_err); end
    finish_vec(res, lat);
    checks++;
    if (res !== expv) begin errors++; $display("FAIL mac_write_result got %0d want %0d", res, expv); end
    start_vec(d);
    finish_vec(res, lat);
    checks++;
    if (res !== expv) begin errors++; $display("FAIL mac_write_rerun got %0d want %0d", res, expv); end
  endtask

  task automatic test_write_conflict();
    logic [N_IN*DW-1:0] d; logic [DW-1:0] res, expv; int lat;
    int n = 0;
    d = rand_vec();
    expv = DW'(model_out(d));
    in_data = d; in_valid = 1'b1;
    w_wr_en = 1'b1; w_wr_addr = AW'(1); w_wr_data = BW'(77);
    while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; w_wr_en = 1'b0; t0 = cyc;
    checks++;
    if (w_err !== 1'b1) begin errors++; $display("FAIL conflict_err got %b want 1", w_err); end
    finish_vec(res, lat);
    checks++;
    if (res !== expv) begin errors++; $display("FAIL conflict_result got %0d want %0d", res, expv); end
  endtask

  task automatic test_bad_addr();
    write_w(11, 5, 1'b1);
    write_w(15, 300, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [N_IN*DW-1:0] d; logic [DW-1:0] res, expv; int lat, prev;
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      d = rand_vec();
      expv = DW'(model_out(d));
      start_vec(d);
      if (prev >= 0) begin
        checks++;
        if (t0 - prev != N_IN + 3) begin
          errors++; $display("FAIL issue_interval got %0d want %0d", t0 - prev, N_IN + 3);
        end
      end
      prev = t0;
      finish_vec(res, lat);
      checks++;
      if (res !== expv) begin errors++; $display("FAIL b2b_result got %0d want %0d", res, expv); end
    end
  endtask

  task automatic test_rounding();
    logic [DW-1:0] res; int lat;
    int biases[3] = '{96, 95, 10000};
    logic [DW-1:0] want[3] = '{8'd2, 8'd1, 8'd127};
    for (int i = 0; i < N_IN; i++) write_w(i, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      write_w(N_IN, biases[k], 1'b0);
      start_vec(rand_vec());
      finish_vec(res, lat);
      checks++;
      if (res !== want[k]) begin
        errors++; $display("FAIL round_bias%0d got %0d want %0d", biases[k], res, want[k]);
      end
    end
  endtask

  task automatic test_negative();
    logic [DW-1:0] res, want; int lat;
    logic [N_IN*DW-1:0] d;
    program_default(0);
    d = '0;
    d[1*DW +: DW] = 8'd127;
`ifdef NODE_RELU_EN
    want = 8'h00;
`else
    want = 8'hE2;
`endif
    start_vec(d);
    finish_vec(res, lat);
    checks++;
    if (res !== want) begin errors++; $display("FAIL negative got %h want %h", res, want); end
  endtask

  task automatic test_random();
    logic [N_IN*DW-1:0] d; logic [DW-1:0] res, expv; int lat;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1) write_w(N_IN, int'($urandom_range(0, 8191)) - 4096, 1'b0);
      repeat ($urandom_range(0, 3)) write_w($urandom_range(0, N_IN - 1), int'($urandom_range(0, 65535)), 1'b0);
      d = rand_vec();
      expv = DW'(model_out(d));
      start_vec(d);
      finish_vec(res, lat);
      checks += 2;
      if (res !== expv)    begin errors++; $display("FAIL random%0d got %0d want %0d", k, res, expv); end
      if (lat != N_IN + 1) begin errors++; $display("FAIL random_latency%0d got %0d want %0d", k, lat, N_IN + 1); end
    end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] res; int lat;
    program_default(1024);
    start_vec(fill_vec(10));
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL abort_in_ready got %b want 0", in_ready); end
    repeat (N_IN + 3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_hold_valid got %b want 0", out_valid); end
    end
    reset = 1'b1;
    for (int i = 0; i < N_IN; i++) mw[i] = 0;
    mb = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_release_ready got %b want 1", in_ready); end
    start_vec(fill_vec(100));
    finish_vec(res, lat);
    checks++;
    if (res !== 8'd0) begin errors++; $display("FAIL abort_cleared_coeffs got %0d want 0", res); end
  endtask

  initial begin
    test_reset();
    test_zero_input();
    test_backpressure();
    test_write_during_mac();
    test_write_conflict();
    test_bad_addr();
    test_back_to_back();
    test_rounding();
    test_negative();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
